// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier: default operand width,
// bit-counter width and derived operand/product widths.
package mult_pkg;

  localparam int N_DEFAULT = 16;
  localparam int CNT_W     = $clog2(N_DEFAULT);
  localparam int OPERAND_W = N_DEFAULT;
  localparam int PRODUCT_W = 2 * N_DEFAULT;

  // Counter width for an arbitrary operand width, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_counter.sv
// Bit counter for the multiplier: counts completed shifts and flags the last step.
module mult_counter
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic inc,
  output logic K
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Explicit wrap keeps the count in range even when N is not a power of two.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign K = (cnt_q == LAST);

endmodule

// File: rtl/mult_datapath.sv
// Datapath of an unsigned shift-and-add multiplier, driven by strobes from an
// external control FSM. The 2N+1-bit accumulator absorbs the adder carry.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Load,
  input  logic           Ad,
  input  logic           Sh,
  input  logic           Done,
  input  logic [N-1:0]   Mplier,
  input  logic [N-1:0]   Mcand,
  output logic           M,
  output logic           K,
  output logic [2*N-1:0] Product,
  output logic           Product_Valid
);

  logic [2*N:0]   acc_q, acc_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0] product_q, product_d;
  logic           valid_q, valid_d;
  logic [2*N:0]   added;
  logic [N:0]     sum;

  assign sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, mcand_q};

  // Product captures the post-step accumulator so Done may ride on the final shift.
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    valid_d   = valid_q;
    added     = acc_q;
    if (Load) begin
      acc_d   = {{(N+1){1'b0}}, Mplier};
      mcand_d = Mcand;
      valid_d = 1'b0;
    end else begin
      if (Ad) added = {sum, acc_q[N-1:0]};
      acc_d = Sh ? (added >> 1) : added;
      if (Done) begin
        product_d = acc_d[2*N-1:0];
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  mult_counter #(.N(N)) u_counter (
    .Clk (Clk),
    .Rst (Rst),
    .clr (Load),
    .inc (Sh & ~Load),
    .K   (K)
  );

  assign M             = acc_q[0];
  assign Product       = product_q;
  assign Product_Valid = valid_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath: plays the control FSM by hand for N=4,
// plus one N=16 full-scale multiply, against hand-computed products.
module tb_mult_datapath;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Load, Ad, Sh, Done;
  logic [3:0] Mplier, Mcand;
  logic       M, K, Product_Valid;
  logic [7:0] Product;

  logic        load16, ad16, sh16, done16;
  logic [15:0] mplier16, mcand16;
  logic        m16, k16, valid16;
  logic [31:0] product16;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] mplier;
    logic [3:0] mcand;
    bit         combined;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[7];

  always #5 Clk = ~Clk;

  mult_datapath #(.N(4)) dut (
    .Clk(Clk), .Rst(Rst), .Load(Load), .Ad(Ad), .Sh(Sh), .Done(Done),
    .Mplier(Mplier), .Mcand(Mcand), .M(M), .K(K),
    .Product(Product), .Product_Valid(Product_Valid)
  );

  mult_datapath #(.N(16)) dut16 (
    .Clk(Clk), .Rst(Rst), .Load(load16), .Ad(ad16), .Sh(sh16), .Done(done16),
    .Mplier(mplier16), .Mcand(mcand16), .M(m16), .K(k16),
    .Product(product16), .Product_Valid(valid16)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    Mplier = a;
    Mcand  = b;
    Load   = 1'b1;
    tick();
    Load   = 1'b0;
  endtask

  // One multiplier bit: optional separate add cycle, then the shift cycle.
  task automatic stepBit(input int idx, input logic [3:0] a, input bit combined, input bit doneOnLast);
    checkOutput($sformatf("M bit %0d", idx), {31'b0, M}, {31'b0, a[idx]});
    checkOutput($sformatf("K at step %0d", idx), {31'b0, K}, {31'b0, (idx == 3)});
    if (a[idx] && !combined) begin
      Ad = 1'b1;
      tick();
      Ad = 1'b0;
    end
    Ad   = a[idx] & combined;
    Sh   = 1'b1;
    Done = doneOnLast && (idx == 3);
    tick();
    Ad   = 1'b0;
    Sh   = 1'b0;
    Done = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int n);
    applyStimulus(v.mplier, v.mcand);
    checkOutput($sformatf("vec%0d valid after load", n), {31'b0, Product_Valid}, 32'd0);
    for (int i = 0; i < 4; i++) stepBit(i, v.mplier, v.combined, 1'b1);
    checkOutput($sformatf("vec%0d product", n), {24'b0, Product}, {24'b0, v.expected});
    checkOutput($sformatf("vec%0d valid", n), {31'b0, Product_Valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{4'd11, 4'd13, 1'b0, 8'h8F};
    vecs[1] = '{4'd15, 4'd15, 1'b1, 8'hE1};
    vecs[2] = '{4'd9,  4'd0,  1'b0, 8'h00};
    vecs[3] = '{4'd0,  4'd15, 1'b0, 8'h00};
    vecs[4] = '{4'd15, 4'd1,  1'b1, 8'h0F};
    vecs[5] = '{4'd3,  4'd5,  1'b0, 8'h0F};
    vecs[6] = '{4'd6,  4'd7,  1'b1, 8'h2A};

    Rst = 1'b1; Load = 0; Ad = 0; Sh = 0; Done = 0; Mplier = 0; Mcand = 0;
    load16 = 0; ad16 = 0; sh16 = 0; done16 = 0; mplier16 = 0; mcand16 = 0;
    #2;
    checkOutput("reset M", {31'b0, M}, 32'd0);
    checkOutput("reset K", {31'b0, K}, 32'd0);
    checkOutput("reset product", {24'b0, Product}, 32'd0);
    checkOutput("reset valid", {31'b0, Product_Valid}, 32'd0);
    tick();
    Rst = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) runVector(vecs[v], v);

    // Result must hold through idle and stray shift cycles.
    tick();
    Sh = 1'b1;
    tick();
    Sh = 1'b0;
    checkOutput("hold product", {24'b0, Product}, 32'h2A);
    checkOutput("hold valid", {31'b0, Product_Valid}, 32'd1);

    // Async reset in the middle of a 13x11 multiply, then 3x5.
    applyStimulus(4'd13, 4'd11);
    stepBit(0, 4'd13, 1'b0, 1'b0);
    checkOutput("pre-reset M", {31'b0, M}, 32'd0);
    stepBit(1, 4'd13, 1'b0, 1'b0);
    checkOutput("pre-reset M bit2", {31'b0, M}, 32'd1);
    #2;
    Rst = 1'b1;
    #1;
    checkOutput("async reset M", {31'b0, M}, 32'd0);
    checkOutput("async reset K", {31'b0, K}, 32'd0);
    checkOutput("async reset product", {24'b0, Product}, 32'd0);
    checkOutput("async reset valid", {31'b0, Product_Valid}, 32'd0);
    tick();
    Rst = 1'b0;
    tick();
    runVector('{4'd3, 4'd5, 1'b0, 8'h0F}, 10);

    // Reload after two shifts of 13x11 must start 7x6 from a clean counter.
    applyStimulus(4'd13, 4'd11);
    stepBit(0, 4'd13, 1'b0, 1'b0);
    stepBit(1, 4'd13, 1'b0, 1'b0);
    applyStimulus(4'd7, 4'd6);
    checkOutput("restart valid", {31'b0, Product_Valid}, 32'd0);
    for (int i = 0; i < 4; i++) stepBit(i, 4'd7, 1'b0, 1'b1);
    checkOutput("restart product", {24'b0, Product}, 32'd42);
    checkOutput("restart valid final", {31'b0, Product_Valid}, 32'd1);

    // Full-width N=16 multiply with add and shift fused every cycle.
    mplier16 = 16'hFFFF;
    mcand16  = 16'hFFFF;
    load16   = 1'b1;
    tick();
    load16   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) checkOutput("n16 K at last step", {31'b0, k16}, 32'd1);
      ad16   = 1'b1;
      sh16   = 1'b1;
      done16 = (i == 15);
      tick();
    end
    ad16 = 0; sh16 = 0; done16 = 0;
    checkOutput("n16 product", product16, 32'hFFFE0001);
    checkOutput("n16 valid", {31'b0, valid16}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
